alu_op_decode: RTL
==================

# alu_op_decode

Decode-and-issue stage that feeds the 64-bit integer ALU. It accepts RV32I-encoded OP (R-type) and OP-IMM (I-type) instruction words together with their register-file operand values. It produces the ALU's operand and function-code inputs (rs1, rs2, funct3, funct7) plus the destination index through a registered valid/ready output. A 2-entry skid buffer decouples upstream fetch/regfile from downstream back-pressure at full throughput.

## Interface
- DATA_WIDTH, 64, operand width.
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_inst_valid  input  1  upstream instruction valid.
- out_inst_ready  output  1  stage can accept this cycle.
- in_inst  input  32  instruction word.
- in_rs1_data  input  DATA_WIDTH  regfile value for inst[19:15].
- in_rs2_data  input  DATA_WIDTH  regfile value for inst[24:20].
- out_alu_valid  output  1  ALU operation valid.
- in_alu_ready  input  1  downstream accepts operation.
- out_rs1  output  DATA_WIDTH  ALU operand A.
- out_rs2  output  DATA_WIDTH  ALU operand B (register or immediate).
- out_funct3  output  3  ALU function.
- out_funct7  output  7  ALU function modifier; only bit 5 is ever set.
- out_rd_addr  output  5  destination register.
- out_illegal  output  1  one-cycle pulse: an illegal word was accepted.
- out_illegal_count  output  16  saturating illegal count (macro only).

## Operation
- Transfer happens on the in side when in_inst_valid && out_inst_ready, and on the out side when out_alu_valid && in_alu_ready.
- Opcode 0110011 (R-type):
  - funct7 0000000 is legal with any funct3.
  - funct7 0100000 is legal only with funct3 000 (SUB) or 101 (SRA).
  - Any other funct7 is illegal.
  - out_rs2 = in_rs2_data; funct3 and funct7 are passed through unchanged.
- Opcode 0010011 (I-type): out_rs2 = inst[31:20] sign-extended to DATA_WIDTH.
  - funct3 001 (SLLI): legal only if inst[31:26]=000000; out_funct7=0000000.
  - funct3 101: inst[31:26]=000000 gives SRLI with funct7 0000000; 010000 gives SRAI with funct7 0100000; anything else is illegal.
  - All other funct3 values: out_funct7=0000000. ADDI never maps to SUB.
- Any other opcode is illegal.
- out_rs1 = in_rs1_data; out_rd_addr = inst[11:7].
- Illegal words are consumed (the handshake completes) and never enter the buffer. out_illegal pulses high the following cycle.
- Buffer states (out_inst_ready = not FULL):
  - EMPTY: accepting a legal word goes to ONE.
  - ONE:
    - accept without consume goes to FULL (word placed in skid register);
    - consume without accept goes to EMPTY;
    - accept with consume stays in ONE, and the output register loads the new word;
    - neither: no change.
  - FULL: consume goes to ONE, and the skid register moves to the output register. No accept is possible in FULL.
- Order is strictly preserved.

## Timing
- Latency is 1 cycle: a legal word accepted at edge N is on the outputs with out_alu_valid=1 after edge N.
- Throughput is 1 op/cycle while in_alu_ready=1.
- out_inst_ready is registered and depends only on state; there is no combinational in_alu_ready to out_inst_ready path.
- While out_alu_valid=1 and in_alu_ready=0, all out_* payload signals hold stable.
- Reset values:
  - out_alu_valid=0, out_illegal=0, out_inst_ready=1, out_illegal_count=0;
  - all payload outputs 0;
  - state EMPTY.
- Reset asserted mid-operation discards both buffered entries immediately, regardless of clk.
- An illegal word accepted while in ONE with a simultaneous consume results in EMPTY plus an out_illegal pulse.

## Configuration
- ALU_DEC_ILLEGAL_CNT_EN:
  - Defined: out_illegal_count increments on every accepted illegal word and saturates at 0xFFFF. It is cleared only by reset.
  - Undefined: the port is tied to 0 and the counter logic is removed.
  - out_illegal behaves identically in both builds.

## Test plan
- add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, in_alu_ready=1 -> next cycle: out_rs1=5, out_rs2=7, funct3=000, funct7=0000000, rd=3, valid=1.
- addi x1,x0,-1 (0xFFF00093), rs1=0 -> out_rs2=0xFFFF_FFFF_FFFF_FFFF, funct3=000, funct7=0000000, rd=1.
- srai x5,x6,63 (0x43F35293) -> funct3=101, funct7=0100000, out_rs2[5:0]=63, rd=5.
- R-type funct7=0100000 with funct3=010 (0x4020A1B3) -> accepted, no out_alu_valid, out_illegal pulse; with macro, count=1.
- Hold in_alu_ready=0 and offer 3 legal words back-to-back -> exactly 2 accepted, out_inst_ready=0 from the third cycle; release -> the 2 ops emerge in order, then the third is accepted.
- Assert reset while FULL -> out_alu_valid=0 and out_inst_ready=1 immediately; no stale op emerges after release.

Source files
------------

// File: rtl/alu_op_decode.sv
// Decode-and-issue stage for RV32I OP/OP-IMM words into 64-bit ALU operands, behind a 2-entry skid buffer.
// Optional saturating illegal-word counter enabled by defining ALU_DEC_ILLEGAL_CNT_EN.
module alu_op_decode #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_inst_valid,
    output logic                  out_inst_ready,
    input  logic [31:0]           in_inst,
    input  logic [DATA_WIDTH-1:0] in_rs1_data,
    input  logic [DATA_WIDTH-1:0] in_rs2_data,
    output logic                  out_alu_valid,
    input  logic                  in_alu_ready,
    output logic [DATA_WIDTH-1:0] out_rs1,
    output logic [DATA_WIDTH-1:0] out_rs2,
    output logic [2:0]            out_funct3,
    output logic [6:0]            out_funct7,
    output logic [4:0]            out_rd_addr,
    output logic                  out_illegal,
    output logic [15:0]           out_illegal_count
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rs1;
        logic [DATA_WIDTH-1:0] rs2;
        logic [2:0]            funct3;
        logic [6:0]            funct7;
        logic [4:0]            rd;
    } op_t;

    state_t state, state_next;
    op_t    op_p0, out_p1, skid_p1;
    logic   legal_p0;
    logic   accept, take, drop, consume;
    logic   load_out, load_skid, from_skid;
    logic   illegal_p1;

    // Source register indices are resolved by the regfile upstream.
    logic unused_rs_idx;
    assign unused_rs_idx = &{1'b0, in_inst[19:15]};

    // Stage 0: combinational decode of the offered word
    always_comb begin
        op_p0.rs1    = in_rs1_data;
        op_p0.rs2    = in_rs2_data;
        op_p0.funct3 = in_inst[14:12];
        op_p0.funct7 = 7'b0000000;
        op_p0.rd     = in_inst[11:7];
        legal_p0     = 1'b0;
        case (in_inst[6:0])
            OPC_OP: begin
                op_p0.funct7 = in_inst[31:25];
                if (in_inst[31:25] == 7'b0000000)
                    legal_p0 = 1'b1;
                else if (in_inst[31:25] == F7_ALT)
                    legal_p0 = (in_inst[14:12] == 3'b000) || (in_inst[14:12] == 3'b101);
            end
            OPC_OP_IMM: begin
                op_p0.rs2 = {{(DATA_WIDTH-12){in_inst[31]}}, in_inst[31:20]};
                legal_p0  = 1'b1;
                if (in_inst[14:12] == 3'b001) begin
                    legal_p0 = (in_inst[31:26] == 6'b000000);
                end else if (in_inst[14:12] == 3'b101) begin
                    if (in_inst[31:26] == 6'b010000)
                        op_p0.funct7 = F7_ALT;
                    else if (in_inst[31:26] != 6'b000000)
                        legal_p0 = 1'b0;
                end
            end
            default: legal_p0 = 1'b0;
        endcase
    end

    assign out_alu_valid  = (state != EMPTY);
    assign out_inst_ready = (state != FULL);

    assign accept  = in_inst_valid && out_inst_ready;
    assign take    = accept && legal_p0;
    assign drop    = accept && !legal_p0;
    assign consume = out_alu_valid && in_alu_ready;

    always_comb begin
        state_next = state;
        load_out   = 1'b0;
        load_skid  = 1'b0;
        from_skid  = 1'b0;
        case (state)
            EMPTY: begin
                if (take) begin
                    state_next = ONE;
                    load_out   = 1'b1;
                end
            end
            ONE: begin
                if (take && !consume) begin
                    state_next = FULL;
                    load_skid  = 1'b1;
                end else if (!take && consume) begin
                    state_next = EMPTY;
                end else if (take && consume) begin
                    load_out   = 1'b1;
                end
            end
            FULL: begin
                if (consume) begin
                    state_next = ONE;
                    load_out   = 1'b1;
                    from_skid  = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Stage 1: output and skid registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            out_p1     <= '0;
            illegal_p1 <= 1'b0;
        end else begin
            state      <= state_next;
            illegal_p1 <= drop;
            if (load_out)
                out_p1 <= from_skid ? skid_p1 : op_p0;
        end
    end

    // The skid entry is only observable after it is written, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load_skid)
            skid_p1 <= op_p0;
    end

    assign out_rs1     = out_p1.rs1;
    assign out_rs2     = out_p1.rs2;
    assign out_funct3  = out_p1.funct3;
    assign out_funct7  = out_p1.funct7;
    assign out_rd_addr = out_p1.rd;
    assign out_illegal = illegal_p1;

`ifdef ALU_DEC_ILLEGAL_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] illegal_cnt_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            illegal_cnt_p1 <= '0;
        else if (drop)
            illegal_cnt_p1 <= sat_inc(illegal_cnt_p1);
    end

    assign out_illegal_count = illegal_cnt_p1;
`else
    assign out_illegal_count = '0;
`endif

endmodule
